mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  6  instruction[31:26] from the instruction register.
REQ-006 alu_zero  in  1  ALU zero flag, used for beq.
REQ-007 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-008 pc_en  out  1  PC load enable = PCWrite | (PCWriteCond & alu_zero).
REQ-009 IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
REQ-010 MemRd, MemWr  out  1 each  memory read/write strobes.
REQ-011 IRWrite  out  1  instruction register load.
REQ-012 RegDst, MemtoReg, RegWr  out  1 each  register-file write controls.
REQ-013 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-014 ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-015 ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded; feeds the existing Alucu.
REQ-016 PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 state_o  out  4  current state encoding, for debug.
REQ-018 illegal_op  out  1  one-cycle pulse on unsupported opcode.
REQ-019 instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-020 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-021 Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Outputs are a function of state only, except mem_ready-gated outputs and pc_en.
REQ-022 Every control output not listed for a state SHALL be 0.
REQ-023 FETCH: MemRd=1, IorD=0, ALUSrcB=01, IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-024 DECODE: ALUSrcB=11. Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other -> FETCH with illegal_op=1.
REQ-025 MEMADR: ALUSrcA=1, ALUSrcB=10. Next state: lw -> MEMRD, sw -> MEMWR.
REQ-026 MEMRD: MemRd=1, IorD=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-027 MEMWB: RegWr=1, MemtoReg=1, RegDst=0. Next state FETCH.
REQ-028 MEMWR: MemWr=1, IorD=1. Hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-029 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB. RWB: RegWr=1, RegDst=1. Next state FETCH.
REQ-030 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Next state FETCH.
REQ-031 JUMP: PCSource=10, PCWrite=1. Next state FETCH.
REQ-032 ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB. ADDIWB: RegWr=1, RegDst=0. Next state FETCH.
REQ-033 instr_done=1 in MEMWB, RWB, BRANCH, JUMP, ADDIWB, and in MEMWR when mem_ready=1; it is 0 otherwise. Illegal opcodes do not retire.
REQ-034 instr_count increments by 1 on each cycle where instr_done=1, and wraps modulo 2^CNT_W without a flag.
REQ-035 Cycle counts with mem_ready tied to 1: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.
REQ-036 The opcode input is sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-037 Unreachable state encodings 12-15 go to FETCH on the next edge, with all outputs 0.

Reset
REQ-038 While rst_n=0: state=FETCH, instr_count=0, illegal_op=0, instr_done=0. Combinational outputs are those of FETCH (MemRd=1, ALUSrcB=01).
REQ-039 Reset asserted mid-instruction, including during a memory wait, aborts the instruction immediately and does not count it.
REQ-040 After rst_n rises, the first rising edge evaluates FETCH normally.

Verification
REQ-041 lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWr=1 and MemtoReg=1 only in state 4; instr_count 0 -> 1.
REQ-042 sw with mem_ready held 0 for 3 cycles in MEMWR -> MemWr=1 for 4 cycles, a single instr_done pulse, no RegWr.
REQ-043 beq with alu_zero=1, then with alu_zero=0 -> pc_en=1 in BRANCH for the first case only; PCSource=01 in both.
REQ-044 Opcode 111111 -> DECODE then FETCH; illegal_op pulse for 1 cycle; instr_count unchanged.
REQ-045 rst_n low during MEMRD wait -> state_o=0 immediately (asynchronous), instr_count=0; execution restarts in FETCH.
REQ-046 Preload instr_count to 0xFFFFFFFF (via 2^32-1 retirements or force), run j -> instr_count=0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode and execute
// phases, with retire pulse, illegal-opcode pulse and retired-instruction counter.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       decode_bad;

    assign state_o    = state;
    assign decode_bad = (state == S_DECODE) &&
                        !((opcode == OP_LW)  || (opcode == OP_SW)  ||
                          (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                          (opcode == OP_J)   || (opcode == OP_ADDI));

    // Encodings 12-15 and any unlisted case fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Everything defaults low so each state only names the strobes it raises.
    always_comb begin
        IorD          = 1'b0;
        MemRd         = 1'b0;
        MemWr         = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWr         = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        instr_done    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRd    = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
            end
            S_MEMWB: begin
                RegWr      = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWr      = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWr      = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                PCSource   = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & alu_zero);

    // illegal_op is registered so it pulses in the FETCH cycle after the bad DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state      <= next_state;
            illegal_op <= decode_bad;
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control: per-cycle state/control/counter
// vectors plus hand sequences for asynchronous reset and counter wrap.
module tb_mc_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_en;
    logic        IorD;
    logic        MemRd;
    logic        MemWr;
    logic        IRWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        RegWr;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  state_o;
    logic        illegal_op;
    logic        instr_done;
    logic [31:0] instr_count;

    int checkCount = 0;
    int failCount  = 0;

    mc_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .MemRd(MemRd),
        .MemWr(MemWr), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWr(RegWr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state_o(state_o), .illegal_op(illegal_op),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word order: pc_en IorD MemRd MemWr IRWrite RegDst MemtoReg RegWr ALUSrcA ALUSrcB ALUOp PCSource
    localparam logic [14:0] C_FRDY  = 15'b1_0_1_0_1_0_0_0_0_01_00_00;
    localparam logic [14:0] C_FWAIT = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
    localparam logic [14:0] C_DEC   = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] C_MADR  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] C_MRD   = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] C_MWB   = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [14:0] C_MWR   = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] C_EXEC  = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [14:0] C_RWB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [14:0] C_BRZ   = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] C_BRNZ  = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] C_JMP   = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [14:0] C_AEX   = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] C_AWB   = 15'b0_0_0_0_0_0_0_1_0_00_00_00;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic        done;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] ctrlWord();
        return {pc_en, IorD, MemRd, MemWr, IRWrite, RegDst, MemtoReg, RegWr,
                ALUSrcA, ALUSrcB, ALUOp, PCSource};
    endfunction

    task automatic addVec(input logic [5:0] op, input logic z, input logic rdy,
                          input logic [3:0] st, input logic [14:0] ctrl,
                          input logic done, input logic ill, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctrl = ctrl;
        v.done = done; v.ill = ill; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
        @(negedge clk);
        opcode    = op;
        alu_zero  = z;
        mem_ready = rdy;
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;

        // lw, no waits: 0,1,2,3,4
        addVec(6'b100011, 0, 1, 4'd0,  C_FRDY,  0, 0, 0);
        addVec(6'b100011, 0, 1, 4'd1,  C_DEC,   0, 0, 0);
        addVec(6'b100011, 0, 1, 4'd2,  C_MADR,  0, 0, 0);
        addVec(6'b100011, 0, 1, 4'd3,  C_MRD,   0, 0, 0);
        addVec(6'b100011, 0, 1, 4'd4,  C_MWB,   1, 0, 0);
        // sw with three wait cycles in MEMWR
        addVec(6'b101011, 0, 1, 4'd0,  C_FRDY,  0, 0, 1);
        addVec(6'b101011, 0, 1, 4'd1,  C_DEC,   0, 0, 1);
        addVec(6'b101011, 0, 1, 4'd2,  C_MADR,  0, 0, 1);
        addVec(6'b101011, 0, 0, 4'd5,  C_MWR,   0, 0, 1);
        addVec(6'b101011, 0, 0, 4'd5,  C_MWR,   0, 0, 1);
        addVec(6'b101011, 0, 0, 4'd5,  C_MWR,   0, 0, 1);
        addVec(6'b101011, 0, 1, 4'd5,  C_MWR,   1, 0, 1);
        // R-type; opcode changes in FETCH wait and in EXEC must be ignored
        addVec(6'b111111, 0, 0, 4'd0,  C_FWAIT, 0, 0, 2);
        addVec(6'b000000, 0, 1, 4'd0,  C_FRDY,  0, 0, 2);
        addVec(6'b000000, 0, 1, 4'd1,  C_DEC,   0, 0, 2);
        addVec(6'b000100, 0, 1, 4'd6,  C_EXEC,  0, 0, 2);
        addVec(6'b000010, 0, 1, 4'd7,  C_RWB,   1, 0, 2);
        // addi
        addVec(6'b001000, 0, 1, 4'd0,  C_FRDY,  0, 0, 3);
        addVec(6'b001000, 0, 1, 4'd1,  C_DEC,   0, 0, 3);
        addVec(6'b001000, 0, 1, 4'd10, C_AEX,   0, 0, 3);
        addVec(6'b001000, 0, 1, 4'd11, C_AWB,   1, 0, 3);
        // beq taken then not taken
        addVec(6'b000100, 0, 1, 4'd0,  C_FRDY,  0, 0, 4);
        addVec(6'b000100, 0, 1, 4'd1,  C_DEC,   0, 0, 4);
        addVec(6'b000100, 1, 1, 4'd8,  C_BRZ,   1, 0, 4);
        addVec(6'b000100, 0, 1, 4'd0,  C_FRDY,  0, 0, 5);
        addVec(6'b000100, 0, 1, 4'd1,  C_DEC,   0, 0, 5);
        addVec(6'b000100, 0, 1, 4'd8,  C_BRNZ,  1, 0, 5);
        // illegal opcode: pulse appears in the following FETCH cycle only
        addVec(6'b111111, 0, 1, 4'd0,  C_FRDY,  0, 0, 6);
        addVec(6'b111111, 0, 1, 4'd1,  C_DEC,   0, 0, 6);
        addVec(6'b111111, 0, 0, 4'd0,  C_FWAIT, 0, 1, 6);
        addVec(6'b111111, 0, 0, 4'd0,  C_FWAIT, 0, 0, 6);
        // j
        addVec(6'b000010, 0, 1, 4'd0,  C_FRDY,  0, 0, 6);
        addVec(6'b000010, 0, 1, 4'd1,  C_DEC,   0, 0, 6);
        addVec(6'b000010, 0, 1, 4'd9,  C_JMP,   1, 0, 6);
        addVec(6'b100011, 0, 1, 4'd0,  C_FRDY,  0, 0, 7);

        // Reset state, with FETCH outputs visible while held
        #2;
        checkOutput("rst.state", 32'(state_o), 32'd0);
        checkOutput("rst.ctrl", 32'(ctrlWord()), 32'(C_FWAIT));
        checkOutput("rst.count", instr_count, 32'd0);
        checkOutput("rst.illegal", 32'(illegal_op), 32'd0);
        checkOutput("rst.done", 32'(instr_done), 32'd0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.hold_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].z, vecs[i].rdy);
            checkOutput($sformatf("row%0d.state", i), 32'(state_o), 32'(vecs[i].st));
            checkOutput($sformatf("row%0d.ctrl", i), 32'(ctrlWord()), 32'(vecs[i].ctrl));
            checkOutput($sformatf("row%0d.done", i), 32'(instr_done), 32'(vecs[i].done));
            checkOutput($sformatf("row%0d.illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
            checkOutput($sformatf("row%0d.count", i), instr_count, vecs[i].cnt);
        end

        // lw continues into a MEMRD wait, then asynchronous reset aborts it
        applyStimulus(6'b100011, 0, 1);
        checkOutput("abort.decode", 32'(state_o), 32'd1);
        applyStimulus(6'b100011, 0, 1);
        checkOutput("abort.memadr", 32'(state_o), 32'd2);
        applyStimulus(6'b100011, 0, 0);
        checkOutput("abort.memrd", 32'(state_o), 32'd3);
        applyStimulus(6'b100011, 0, 0);
        checkOutput("abort.memrd_wait", 32'(state_o), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.async_state", 32'(state_o), 32'd0);
        checkOutput("abort.async_count", instr_count, 32'd0);
        checkOutput("abort.async_ctrl", 32'(ctrlWord()), 32'(C_FWAIT));
        @(negedge clk);
        rst_n = 1'b1;

        // Restart with j, then preload the counter to all ones and retire another j
        applyStimulus(6'b000010, 0, 1);
        checkOutput("restart.fetch", 32'(state_o), 32'd0);
        checkOutput("restart.count", instr_count, 32'd0);
        applyStimulus(6'b000010, 0, 1);
        checkOutput("restart.decode", 32'(state_o), 32'd1);
        applyStimulus(6'b000010, 0, 1);
        checkOutput("restart.jump", 32'(state_o), 32'd9);
        checkOutput("restart.jump_done", 32'(instr_done), 32'd1);
        applyStimulus(6'b000010, 0, 0);
        checkOutput("restart.count1", instr_count, 32'd1);
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        #1;
        checkOutput("wrap.preload", instr_count, 32'hFFFF_FFFF);
        applyStimulus(6'b000010, 0, 1);
        checkOutput("wrap.hold", instr_count, 32'hFFFF_FFFF);
        applyStimulus(6'b000010, 0, 1);
        checkOutput("wrap.decode", 32'(state_o), 32'd1);
        applyStimulus(6'b000010, 0, 1);
        checkOutput("wrap.jump", 32'(state_o), 32'd9);
        checkOutput("wrap.pc_en", 32'(pc_en), 32'd1);
        applyStimulus(6'b000010, 0, 0);
        checkOutput("wrap.state", 32'(state_o), 32'd0);
        checkOutput("wrap.count", instr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
